// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I inter-stage buffers: occupancy encoding
// and the control-field width carried by each pipeline boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_occ_t;

  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int EX_MEM_CTRL_W = 5;
  localparam int MEM_WB_CTRL_W = 3;

endpackage

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage with an optional two-entry skid buffer.
// Slot M always drives the outputs; slot S only catches the beat in flight when downstream stalls.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_occ_t         state;
  pipe_occ_t         next_state;
  logic              accept;
  logic              deliver;
  logic              load_m_in;
  logic              load_m_skid;
  logic              load_s;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) next_state = ONE;
        ONE: begin
          if (accept && !deliver) begin
            next_state = FULL;
          end else if (!accept && deliver) begin
            next_state = EMPTY;
          end
        end
        FULL:    if (deliver) next_state = ONE;
        default: next_state = EMPTY;
      endcase
    end
  end

  // With SKID the ready is a pure state decode so it can be registered-quality
  // timing; without it, ready must look through to out_ready to keep full rate.
  always_comb begin
    out_valid = (state != EMPTY);
    if (SKID != 0) begin
      in_ready = (state != FULL);
    end else begin
      in_ready = (state == EMPTY) || out_ready;
    end
    out_ctrl  = out_valid ? m_ctrl : '0;
    out_data  = m_data;
    occupancy = state;
  end

  always_comb begin
    load_m_in   = accept && ((state == EMPTY) || ((state == ONE) && deliver));
    load_s      = accept && (state == ONE) && !deliver;
    load_m_skid = deliver && (state == FULL);
  end

  // Flush only needs to clear ctrl so a squashed slot can never leak a
  // RegWrite/MemWrite; the data bits are don't-care once the slot is empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ctrl <= '0;
      m_data <= '0;
    end else if (flush) begin
      m_ctrl <= '0;
    end else if (load_m_in) begin
      m_ctrl <= in_ctrl;
      m_data <= in_data;
    end else if (load_m_skid) begin
      m_ctrl <= s_ctrl;
      m_data <= s_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s_ctrl <= '0;
          s_data <= '0;
        end else if (flush) begin
          s_ctrl <= '0;
        end else if (load_s) begin
          s_ctrl <= in_ctrl;
          s_data <= in_data;
        end
      end
    end else begin : g_no_skid
      assign s_ctrl = '0;
      assign s_data = '0;
    end
  endgenerate

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised inter-stage pipeline buffer for the RV32I pipeline. It replaces the fixed, always-advancing stage registers with a valid/ready handshaked stage. The stage carries a generic payload plus a control field that is guaranteed zero whenever the stage holds a bubble. An optional two-entry skid buffer gives full throughput with a registered `in_ready`, and a synchronous flush squashes the stage for branch redirect or trap.

## Interface
- `DATA_W`, 96, width of the payload (PC+4, ALU result, store data, etc., concatenated by the instantiating stage).
- `CTRL_W`, 8, width of the control field (RegWrite, MemWrite, MemRead, MemToReg select, funct); forced to 0 on bubbles.
- `SKID`, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `in_ctrl`  in  CTRL_W  upstream control field.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  downstream beat valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_ctrl`  out  CTRL_W  control field; 0 whenever `out_valid`=0.
- `out_data`  out  DATA_W  payload.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- Two storage slots: main M, which drives the outputs, and skid S, which exists only when SKID=1.
- Accept is defined as `in_valid && in_ready`. Deliver is defined as `out_valid && out_ready`.
- State machine, encoded as occupancy:
  - EMPTY:
    - accept: M<=in, go to ONE.
    - otherwise: stay EMPTY.
  - ONE:
    - accept and deliver: M<=in, stay ONE.
    - accept without deliver: S<=in, go to FULL.
    - deliver without accept: go to EMPTY.
    - otherwise: hold.
  - FULL:
    - deliver: M<=S, go to ONE.
    - otherwise: hold.
    - No accept is possible in FULL.
- `in_ready`:
  - SKID=1: `in_ready` = (state != FULL), decoded from the state register only. There is no combinational path from `out_ready`.
  - SKID=0: `in_ready` = (state==EMPTY) || `out_ready`. FULL is unreachable.
- `out_valid` = (state != EMPTY).
- `out_ctrl` = `out_valid` ? M.ctrl : 0.
- `out_data` = M.data.
- Flush has the highest priority:
  - The state goes to EMPTY and both ctrl slots are cleared to 0. Data slots hold their values, which are don't-care.
  - A beat accepted in the flush cycle is discarded.
  - A beat delivered in the flush cycle counts as delivered; the downstream handshake is not retracted.
- Ordering is strictly FIFO. No beat is dropped or duplicated except by flush.

## Timing
- Reset (`reset_n` low), asynchronous:
  - state=EMPTY, all slots 0.
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=1, for both SKID settings.
- Latency: 1 cycle. A beat accepted at edge N is visible on the outputs after edge N.
- Throughput: 1 beat/cycle sustained when `out_ready`=1.
- Backpressure, SKID=1: after the first stalled cycle, at most one additional beat is absorbed. `in_ready` drops the cycle after FULL is entered.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_ctrl` are held stable.
- Reset mid-operation: all entries are lost immediately. No beat is emitted after reset until a new accept.
- `flush` together with `in_valid`: the stage is EMPTY on the next cycle and `in_ready`=1.

## Structure
- Package `pipe_pkg`:
  - occupancy state enum `pipe_occ_t` with values EMPTY=0, ONE=1, FULL=2.
  - localparam for the control-field width of each pipeline stage.
- No sub-module is needed. The design is one state register, two slot registers, and output muxing, with the S slot generated only when SKID=1.

## Test plan
- Reset with `in_valid`=1 held, then release:
  - During reset: `out_valid`=0, `out_ctrl`=0, `in_ready`=1.
  - Beat ctrl=0xA5, data=0x1234 appears one cycle after the first accepting edge.
- Streaming of 10 beats with `out_ready`=1, SKID=1: outputs match inputs in order, one per cycle, `occupancy`=1 throughout.
- Backpressure, SKID=1:
  - Drop `out_ready` for 3 cycles while `in_valid`=1: `occupancy` goes 1→2, `in_ready`=0 on the following cycle.
  - Output held stable while stalled.
  - On release, beats drain in order with no loss.
- Flush in FULL state:
  - Next cycle: `out_valid`=0, `out_ctrl`=0x00, `occupancy`=0, `in_ready`=1.
  - The beat offered in the flush cycle never appears.
- SKID=0 stall: with `out_ready`=0, `in_ready` is 0 in the same cycle. Toggling `out_ready` 1/0 passes beats with no duplicates.
- Random `in_valid`/`out_ready`/`flush` over 10k cycles against a queue scoreboard:
  - FIFO order holds and no beats are lost outside flush.
  - `out_ctrl`=0 whenever `out_valid`=0.
